// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: access-size encodings,
// responder state enum, data width and wait-counter width.
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage, 2**ADDR_W x 8, no reset.
// Ports:
//   CLK     clock
//   addr    address of the first (most significant) byte of the 4-byte window
//   lane_we byte-lane write enables; lane_we[3] is the byte at addr,
//           lane_we[0] the byte at addr+3
//   wdata   write data, wdata[31:24] goes to addr
//   rdata   big-endian read of addr..addr+3 (addresses wrap at the array end)
module mem_byte_array #(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        lane_we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_we[3-i]) begin
                mem[addr + ADDR_W'(i)] <= wdata[8*(3-i) +: 8];
            end
        end
    end

    assign rdata = {mem[addr],
                    mem[addr + ADDR_W'(1)],
                    mem[addr + ADDR_W'(2)],
                    mem[addr + ADDR_W'(3)]};

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves CPU byte/halfword/word requests from an
// internal big-endian byte RAM and signals completion with MOC.
// Optional build macro: MEM_MISALIGN_FAULT_EN adds the FAULT output and
// blocks misaligned halfword/word accesses instead of masking them.
// Ports:
//   CLK, RST  clock, synchronous active-high reset
//   MFA       request active, held by the CPU until MOC
//   RW        1 = read, 0 = write
//   SIZE      00 byte, 01 halfword, 10/11 word
//   ADDR      byte address (only the low ADDR_W bits are used)
//   DATA_IN   right-justified write data
//   DATA_OUT  right-justified, zero-extended read data
//   MOC       operation complete
//   FAULT     misaligned access flag (only with MEM_MISALIGN_FAULT_EN)
//
// state  | meaning
// IDLE   | waiting for MFA, request fields latched on acceptance
// ACCESS | counting wait states; operation performed when counter is 0
// DONE   | MOC high, waiting for MFA to drop
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        SIZE,
    input  logic [31:0]       ADDR,
    input  logic [DATA_W-1:0] DATA_IN,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              MOC
`ifdef MEM_MISALIGN_FAULT_EN
   ,output logic              FAULT
`endif
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              rw_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] dout_q;

    logic              access_done;
    logic              misalign;
    logic [ADDR_W-1:0] base_addr;
    logic [3:0]        size_lanes;
    logic [3:0]        lane_we;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic [DATA_W-1:0] read_val;

    // Upper address bits are deliberately ignored so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^ADDR[31:ADDR_W];

    assign access_done = (state_q == ACCESS) && (cnt_q == '0);

`ifdef MEM_MISALIGN_FAULT_EN
    logic fault_q;
    assign misalign = ((size_q == SZ_HALF) && addr_q[0]) ||
                      (size_q[1] && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (MFA)          state_d = ACCESS;
            ACCESS:  if (cnt_q == '0)  state_d = DONE;
            DONE:    if (!MFA)         state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        MOC      = (state_q == DONE);
        DATA_OUT = dout_q;
`ifdef MEM_MISALIGN_FAULT_EN
        FAULT    = (state_q == DONE) && fault_q;
`endif
    end

    // Lane steering: the access always starts at lane 3 (the MSB byte),
    // with the base address masked down to the access size.
    always_comb begin
        case (size_q)
            SZ_BYTE: begin
                base_addr  = addr_q;
                size_lanes = 4'b1000;
                lane_wdata = {wdata_q[7:0], 24'h0};
                read_val   = {24'h0, lane_rdata[31:24]};
            end
            SZ_HALF: begin
                base_addr  = {addr_q[ADDR_W-1:1], 1'b0};
                size_lanes = 4'b1100;
                lane_wdata = {wdata_q[15:0], 16'h0};
                read_val   = {16'h0, lane_rdata[31:16]};
            end
            default: begin
                base_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                size_lanes = 4'b1111;
                lane_wdata = wdata_q;
                read_val   = lane_rdata;
            end
        endcase
        // RST on the completing edge aborts the write.
        lane_we = (access_done && !rw_q && !misalign && !RST) ? size_lanes : 4'b0000;
    end

    // Request latch, wait counter and read-data register
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= '0;
            dout_q  <= '0;
`ifdef MEM_MISALIGN_FAULT_EN
            fault_q <= 1'b0;
`endif
        end else begin
            if (state_q == IDLE && MFA) begin
                rw_q    <= RW;
                size_q  <= SIZE;
                addr_q  <= ADDR[ADDR_W-1:0];
                wdata_q <= DATA_IN;
                cnt_q   <= CNT_W'(WAIT_CYCLES);
            end else if (state_q == ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (access_done && rw_q && !misalign) begin
                dout_q <= read_val;
            end
`ifdef MEM_MISALIGN_FAULT_EN
            if (access_done) begin
                fault_q <= misalign;
            end
`endif
        end
    end

    mem_byte_array #(.ADDR_W(ADDR_W)) u_array (
        .CLK     (CLK),
        .addr    (base_addr),
        .lane_we (lane_we),
        .wdata   (lane_wdata),
        .rdata   (lane_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    import mem_pkg::*;

    localparam int ADDR_W      = 8;
    localparam int WAIT_CYCLES = 1;
    localparam int DEPTH       = 2 ** ADDR_W;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MFA;
    logic        RW;
    logic [1:0]  SIZE;
    logic [31:0] ADDR;
    logic [31:0] DATA_IN;
    logic [31:0] DATA_OUT;
    logic        MOC;
`ifdef MEM_MISALIGN_FAULT_EN
    logic        FAULT;
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    always #5 CLK = ~CLK;

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .MFA      (MFA),
        .RW       (RW),
        .SIZE     (SIZE),
        .ADDR     (ADDR),
        .DATA_IN  (DATA_IN),
        .DATA_OUT (DATA_OUT),
        .MOC      (MOC)
`ifdef MEM_MISALIGN_FAULT_EN
       ,.FAULT    (FAULT)
`endif
    );

    int          n_cmp = 0;
    int          n_err = 0;
    byte unsigned ref_mem [DEPTH];
    logic [31:0] ref_dout;
    logic        ref_fault;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Reference: apply one request to the byte model, returns whether it faulted.
    function automatic bit ref_apply(input bit rw, input logic [1:0] sz,
                                     input logic [31:0] addr, input logic [31:0] wdata);
        int nb   = nbytes(sz);
        int a    = int'(addr % DEPTH);
        int base = a - (a % nb);
        bit mis  = FEAT && ((a % nb) != 0);
        logic [31:0] v = 0;
        if (mis) return 1'b1;
        if (rw) begin
            for (int i = 0; i < nb; i++) v = (v << 8) | 32'(ref_mem[base + i]);
            ref_dout = v;
        end else begin
            for (int i = 0; i < nb; i++) ref_mem[base + i] = 8'(wdata >> (8 * (nb - 1 - i)));
        end
        return 1'b0;
    endfunction

    task automatic do_req(input bit rw, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input string tag);
        int edges = 0;
        ref_fault = ref_apply(rw, sz, addr, wdata);
        @(negedge CLK);
        MFA = 1'b1; RW = rw; SIZE = sz; ADDR = addr; DATA_IN = wdata;
        do begin
            @(posedge CLK);
            edges++;
            #1;
            if (edges == 1) begin
                // request must already be latched; scramble the bus
                RW = 1'($urandom); SIZE = 2'($urandom); ADDR = $urandom; DATA_IN = $urandom;
            end
        end while (!MOC && edges < 40);
        check_val({tag, "/lat"}, 32'(edges), 32'(WAIT_CYCLES + 2));
        check_val({tag, "/dout"}, DATA_OUT, ref_dout);
`ifdef MEM_MISALIGN_FAULT_EN
        check_val({tag, "/fault"}, 32'(FAULT), 32'(ref_fault));
`endif
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK); #1;
            check_val({tag, "/hold_moc"}, 32'(MOC), 32'd1);
            check_val({tag, "/hold_dout"}, DATA_OUT, ref_dout);
        end
        @(negedge CLK);
        MFA = 1'b0;
        @(posedge CLK); #1;
        check_val({tag, "/moc_fall"}, 32'(MOC), 32'd0);
`ifdef MEM_MISALIGN_FAULT_EN
        check_val({tag, "/fault_fall"}, 32'(FAULT), 32'd0);
`endif
    endtask

    initial begin
        RST = 1'b1; MFA = 1'b0; RW = 1'b0; SIZE = 2'b00; ADDR = '0; DATA_IN = '0;
        ref_dout = '0;
        ref_fault = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_moc", 32'(MOC), 32'd0);
        check_val("rst_dout", DATA_OUT, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Give every byte a known value.
        for (int a = 0; a < DEPTH; a += 4) do_req(1'b0, SZ_WORD, 32'(a), $urandom, 0, "init");

        do_req(1'b0, SZ_WORD, 32'h10, 32'hDEADBEEF, 0, "wr_w10");
        do_req(1'b1, SZ_WORD, 32'h10, 32'h0, 0, "rd_w10");
        check_val("rd_w10_const", DATA_OUT, 32'hDEADBEEF);
        do_req(1'b1, SZ_BYTE, 32'h10, 32'h0, 0, "rd_b10");
        check_val("rd_b10_const", DATA_OUT, 32'h000000DE);
        do_req(1'b1, SZ_BYTE, 32'h13, 32'h0, 0, "rd_b13");
        check_val("rd_b13_const", DATA_OUT, 32'h000000EF);
        do_req(1'b1, SZ_HALF, 32'h12, 32'h0, 0, "rd_h12");
        check_val("rd_h12_const", DATA_OUT, 32'h0000BEEF);
        do_req(1'b0, SZ_BYTE, 32'h11, 32'hFFFFFF5A, 0, "wr_b11");
        do_req(1'b1, SZ_WORD, 32'h10, 32'h0, 0, "rd_w10b");
        check_val("rd_w10b_const", DATA_OUT, 32'hDE5ABEEF);

        do_req(1'b0, SZ_WORD, 32'h14, 32'h0BADF00D, 0, "wr_w14");
        do_req(1'b1, SZ_WORD, 32'h0000_0114, 32'h0, 0, "rd_wrap");
        check_val("rd_wrap_const", DATA_OUT, 32'h0BADF00D);

        do_req(1'b1, SZ_BYTE, 32'h13, 32'h0, 0, "rd_b13b");
        do_req(1'b1, SZ_WORD, 32'h12, 32'h0, 0, "rd_mis");
        check_val("rd_mis_const", DATA_OUT, FEAT ? 32'h000000EF : 32'hDE5ABEEF);
        do_req(1'b0, SZ_WORD, 32'h12, 32'h12345678, 0, "wr_mis");
        do_req(1'b1, SZ_WORD, 32'h10, 32'h0, 0, "rd_after_mis");
        check_val("rd_after_mis_const", DATA_OUT, FEAT ? 32'hDE5ABEEF : 32'h12345678);

        do_req(1'b1, SZ_HALF, 32'h10, 32'h0, 5, "hold");

        // Reset on the edge that would perform the write.
        do_req(1'b1, SZ_WORD, 32'h20, 32'h0, 0, "rd_pre_abort");
        @(negedge CLK);
        MFA = 1'b1; RW = 1'b0; SIZE = SZ_WORD; ADDR = 32'h20; DATA_IN = 32'h11223344;
        @(posedge CLK);
        repeat (WAIT_CYCLES) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_val("abort_moc", 32'(MOC), 32'd0);
        check_val("abort_dout", DATA_OUT, 32'd0);
        @(negedge CLK);
        RST = 1'b0; MFA = 1'b0;
        ref_dout = '0;
        @(posedge CLK); #1;
        check_val("abort_moc2", 32'(MOC), 32'd0);
        do_req(1'b1, SZ_WORD, 32'h20, 32'h0, 0, "rd_post_abort");

        for (int n = 0; n < 150; n++) begin
            do_req(1'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom,
                   int'($urandom_range(0, 2)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU memory interface.
- The CPU drives a request from its address/data registers: address from MAR, write data from MDR, control signals from the control unit. This block serves the request from an internal byte-addressed RAM.
- It returns read data toward MDR and signals completion with MOC (memory operation complete).
- Supports byte, halfword and word accesses, big-endian, with a parameterised wait-state count.

Parameters:
- ADDR_W, 8, RAM index width in bits; depth = 2**ADDR_W bytes.
- WAIT_CYCLES, 1, extra wait states spent in ACCESS before the operation completes (0..15).

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  reset, synchronous and active-high.
- MFA  in  1  memory function active; the CPU holds it high until MOC is seen.
- RW  in  1  1 = read, 0 = write.
- SIZE  in  2  00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- ADDR  in  32  byte address from MAR.
- DATA_IN  in  32  write data from MDR, right-justified.
- DATA_OUT  out  32  read data, right-justified and zero-extended.
- MOC  out  1  operation complete.

Behaviour:
- Reset (synchronous, RST=1 at a rising edge):
  - state=IDLE, MOC=0, DATA_OUT=0, wait counter=0.
  - RAM contents are not cleared.
  - RST during ACCESS aborts the operation: no RAM write, DATA_OUT forced to 0.
- FSM states IDLE, ACCESS, DONE:
  - IDLE: when MFA=1 is sampled, latch RW, SIZE, ADDR[ADDR_W-1:0] and DATA_IN; load counter=WAIT_CYCLES; go to ACCESS. Later changes on these inputs are ignored until the next IDLE.
  - ACCESS: if counter != 0, decrement. If counter == 0, perform the operation, go to DONE, assert MOC.
  - DONE: hold MOC=1 and DATA_OUT. When MFA=0 is sampled, go to IDLE and clear MOC.
- Latency: counting the edge that samples MFA=1 as edge 1, MOC rises at edge WAIT_CYCLES+2. With WAIT_CYCLES=0 this is edge 2.
- Back-to-back requests: MFA must be sampled low at least once (the DONE->IDLE handshake). A new request is accepted at the earliest on the edge after MOC falls.
- MFA dropped during ACCESS: ignored; the operation completes. DONE then exits on the next edge because MFA=0.
- Addressing:
  - Upper ADDR bits above ADDR_W are ignored, so addresses wrap modulo the depth.
  - Big-endian ordering: byte a holds the MSB of a word.
  - Halfword and word accesses mask the low address bits (a & ~1, a & ~3). Alignment therefore never crosses the array end.
- Write: byte stores DATA_IN[7:0]; halfword stores DATA_IN[15:0]; word stores DATA_IN[31:0]. Bytes outside the access size are untouched.
- Read:
  - DATA_OUT is updated on the ACCESS->DONE edge: byte -> {24'b0, m[a]}; halfword -> {16'b0, m[a], m[a+1]}; word -> m[a..a+3].
  - DATA_OUT holds its value until the next read completes; writes leave it unchanged.
- Read-after-write to the same address in consecutive requests returns the new data.

Optional Feature:
- Macro: MEM_MISALIGN_FAULT_EN.
- Defined:
  - Adds output FAULT (1 bit), reset 0.
  - A halfword with ADDR[0]=1, or a word with ADDR[1:0] != 0, performs no RAM access and leaves DATA_OUT unchanged.
  - Such an access still completes with normal latency; FAULT rises and falls together with MOC.
- Undefined: no FAULT port; misaligned accesses silently mask the low address bits as above.

Decomposition:
- Package mem_pkg holds:
  - SIZE encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum {IDLE, ACCESS, DONE};
  - constant DATA_W=32;
  - the wait counter width (4).
- Natural sub-module: mem_byte_array. It is the 2**ADDR_W x 8 storage with four byte-lane write enables and a 4-byte big-endian read port. mem_responder instantiates it and contains the FSM plus the lane steering.

Test Plan:
- WAIT_CYCLES=1: write word 0xDEADBEEF @0x10, then read word @0x10 -> DATA_OUT=0xDEADBEEF. MOC rises at edge 3 after the MFA sample.
- After the word write: read byte @0x10 -> 0x000000DE; byte @0x13 -> 0x000000EF; halfword @0x12 -> 0x0000BEEF.
- Write byte 0x5A @0x11, then read word @0x10 -> 0xDE5ABEEF. Other bytes are unchanged.
- Read word @0x0000_0114 with ADDR_W=8 -> returns the word @0x14 (wrap).
- Misaligned word read @0x12:
  - feature off -> data from @0x10;
  - feature on -> FAULT=1 with MOC, DATA_OUT unchanged, and a write attempt leaves the RAM unchanged.
- Assert RST in ACCESS during a write of 0x11223344 @0x20 -> MOC stays 0, DATA_OUT=0, and a later read @0x20 returns the previous contents. Also hold MFA high in DONE for 5 cycles -> MOC stays 1 and no second access occurs.
